// File: rtl/interrupt_mask_sequencer.sv
// Interrupt mask sequencer: opens a timed masked window on request, holds it while
// hold is asserted, and replays any NMI falling edge seen inside the window as a
// clean low pulse once the window closes.
module interrupt_mask_sequencer #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned NMI_PULSE    = 4,
  parameter int unsigned CW           = 8
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic req,
  input  logic hold,
  input  logic nNMIx,
  output logic nNMI,
  output logic mask,
  output logic busy,
  output logic nmi_pending
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StMasked = 2'd1;
  localparam logic [1:0] StGuard  = 2'd2;
  localparam logic [1:0] StReplay = 2'd3;

  localparam logic [CW-1:0] HoldLoad  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GuardLoad = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] PulseLoad = CW'(NMI_PULSE - 1);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  logic [1:0]    r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_mask, w_mask;
  logic          r_nnmi, w_nnmi;
  logic          r_nmi_pending, w_nmi_pending;
  logic          r_req_pend, w_req_pend;
  logic          r_nmi_prev;
  logic          w_fall;
  logic          w_cnt_zero;

  assign w_fall     = r_nmi_prev & ~nNMIx;
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state logic for the window sequencer.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_mask        = r_mask;
    w_nnmi        = r_nnmi;
    w_nmi_pending = r_nmi_pending;
    w_req_pend    = r_req_pend;
    case (r_state)
      StIdle: begin
        w_nnmi = nNMIx;
        w_mask = 1'b0;
        if (req || r_req_pend) begin
          w_state    = StMasked;
          w_cnt      = HoldLoad;
          w_mask     = 1'b1;
          w_nnmi     = 1'b1;
          w_req_pend = 1'b0;
        end
      end
      StMasked: begin
        w_nnmi = 1'b1;
        w_mask = 1'b1;
        if (w_fall) w_nmi_pending = 1'b1;
        if (req) begin
          w_cnt = HoldLoad;
        end else if (w_cnt_zero) begin
          // hold only matters once the count has run out
          if (!hold) begin
            w_state = StGuard;
            w_cnt   = GuardLoad;
          end
        end else begin
          w_cnt = r_cnt - CntOne;
        end
      end
      StGuard: begin
        w_nnmi = 1'b1;
        w_mask = 1'b1;
        if (req) begin
          w_state = StMasked;
          w_cnt   = HoldLoad;
          if (w_fall) w_nmi_pending = 1'b1;
        end else if (w_cnt_zero) begin
          // a fall on the exit cycle is folded into the replay
          if (r_nmi_pending || w_fall) begin
            w_state       = StReplay;
            w_mask        = 1'b0;
            w_nnmi        = 1'b0;
            w_cnt         = PulseLoad;
            w_nmi_pending = 1'b0;
          end else begin
            w_state = StIdle;
            w_mask  = 1'b0;
          end
        end else begin
          w_cnt = r_cnt - CntOne;
          if (w_fall) w_nmi_pending = 1'b1;
        end
      end
      StReplay: begin
        w_mask = 1'b0;
        w_nnmi = 1'b0;
        // a request here is deferred to the following idle cycle
        if (req) w_req_pend = 1'b1;
        if (w_cnt_zero) begin
          w_state = StIdle;
          w_nnmi  = 1'b1;
        end else begin
          w_cnt = r_cnt - CntOne;
        end
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  // State and output registers; reset discards any pending NMI.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_mask        <= 1'b0;
      r_nnmi        <= 1'b1;
      r_nmi_pending <= 1'b0;
      r_req_pend    <= 1'b0;
      r_nmi_prev    <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_mask        <= w_mask;
      r_nnmi        <= w_nnmi;
      r_nmi_pending <= w_nmi_pending;
      r_req_pend    <= w_req_pend;
      r_nmi_prev    <= nNMIx;
    end
  end

  assign nNMI        = r_nnmi;
  assign mask        = r_mask;
  assign busy        = (r_state != StIdle);
  assign nmi_pending = r_nmi_pending;

endmodule

// File: tb/tb_interrupt_mask_sequencer.sv
// Directed bench for interrupt_mask_sequencer with the default 16/2/4 timing.
// Cycle c is the period after the c-th clock edge following reset release;
// inputs change just after the rising edge, outputs are sampled on the falling edge.
module tb_interrupt_mask_sequencer;

  logic CLK;
  logic nRESET;
  logic req;
  logic hold;
  logic nNMIx;
  logic nNMI;
  logic mask;
  logic busy;
  logic nmi_pending;

  int n_total;
  int n_bad;

  interrupt_mask_sequencer #(
    .HOLD_CYCLES (16),
    .GUARD_CYCLES(2),
    .NMI_PULSE   (4),
    .CW          (8)
  ) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .req        (req),
    .hold       (hold),
    .nNMIx      (nNMIx),
    .nNMI       (nNMI),
    .mask       (mask),
    .busy       (busy),
    .nmi_pending(nmi_pending)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reset, check reset outputs, release between edges, land at start of cycle 0.
  task automatic do_reset();
    nRESET = 1'b0;
    req    = 1'b0;
    hold   = 1'b0;
    nNMIx  = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst mask", mask, 1'b0);
    check_eq("rst nNMI", nNMI, 1'b1);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst pend", nmi_pending, 1'b0);
    nRESET = 1'b1;
    next_cycle();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    // T1: plain window, 16 hold + 2 guard cycles
    do_reset();
    for (int c = 0; c < 22; c++) begin
      req = (c == 0);
      @(negedge CLK);
      check_eq($sformatf("t1 mask c%0d", c), mask, (c >= 1 && c <= 18));
      check_eq($sformatf("t1 busy c%0d", c), busy, (c >= 1 && c <= 18));
      check_eq($sformatf("t1 nNMI c%0d", c), nNMI, 1'b1);
      next_cycle();
    end

    // T2: NMI falls inside window (twice, coalesced), replayed after guard
    do_reset();
    for (int c = 0; c < 27; c++) begin
      req   = (c == 0);
      nNMIx = !(c == 5 || c == 6 || c == 10);
      @(negedge CLK);
      check_eq($sformatf("t2 pend c%0d", c), nmi_pending, (c >= 6 && c <= 18));
      check_eq($sformatf("t2 mask c%0d", c), mask, (c >= 1 && c <= 18));
      check_eq($sformatf("t2 nNMI c%0d", c), nNMI, !(c >= 19 && c <= 22));
      check_eq($sformatf("t2 busy c%0d", c), busy, (c >= 1 && c <= 22));
      next_cycle();
    end
    nNMIx = 1'b1;

    // T3: hold keeps the window open until it drops, then guard
    do_reset();
    for (int c = 0; c < 37; c++) begin
      req  = (c == 0);
      hold = (c <= 30);
      @(negedge CLK);
      check_eq($sformatf("t3 mask c%0d", c), mask, (c >= 1 && c <= 33));
      next_cycle();
    end
    hold = 1'b0;

    // T4: retrigger in MASKED reloads the hold count
    do_reset();
    for (int c = 0; c < 31; c++) begin
      req = (c == 0 || c == 10);
      @(negedge CLK);
      check_eq($sformatf("t4 mask c%0d", c), mask, (c >= 1 && c <= 28));
      next_cycle();
    end

    // T7: req during GUARD returns to MASKED with a fresh hold count
    do_reset();
    for (int c = 0; c < 38; c++) begin
      req = (c == 0 || c == 17);
      @(negedge CLK);
      check_eq($sformatf("t7 mask c%0d", c), mask, (c >= 1 && c <= 35));
      next_cycle();
    end

    // T5: reset mid-window with NMI pending discards everything
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req   = (c == 0);
      nNMIx = (c != 3);
      @(negedge CLK);
      check_eq($sformatf("t5 pend c%0d", c), nmi_pending, (c >= 4));
      next_cycle();
    end
    nRESET = 1'b0;
    #1;
    check_eq("t5 async mask", mask, 1'b0);
    check_eq("t5 async nNMI", nNMI, 1'b1);
    check_eq("t5 async pend", nmi_pending, 1'b0);
    check_eq("t5 async busy", busy, 1'b0);
    @(negedge CLK);
    nRESET = 1'b1;
    next_cycle();
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      check_eq($sformatf("t5 post nNMI c%0d", c), nNMI, 1'b1);
      check_eq($sformatf("t5 post mask c%0d", c), mask, 1'b0);
      next_cycle();
    end

    // T6: idle pass-through, then req during REPLAY re-enters after one idle cycle
    do_reset();
    for (int c = 0; c < 37; c++) begin
      req   = (c == 10 || c == 30);
      nNMIx = !((c >= 3 && c <= 6) || c == 12);
      @(negedge CLK);
      check_eq($sformatf("t6 nNMI c%0d", c), nNMI,
               !((c >= 4 && c <= 7) || (c >= 29 && c <= 32)));
      check_eq($sformatf("t6 mask c%0d", c), mask, ((c >= 11 && c <= 28) || c >= 34));
      check_eq($sformatf("t6 busy c%0d", c), busy, ((c >= 11 && c <= 32) || c >= 34));
      check_eq($sformatf("t6 pend c%0d", c), nmi_pending, (c >= 13 && c <= 28));
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
